wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default `REG_WIDTH (32), register write-data width.
REQ-002 SHALL have parameter DEPTH, default 2, load-response queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ex_valid  input  1  execute-path writeback request (ALU result or PC+4).
REQ-006 SHALL have port ex_rd  input  5  execute-path destination register.
REQ-007 SHALL have port ex_data  input  DATA_W  execute-path write data.
REQ-008 SHALL have port ex_ready  output  1  execute request granted this cycle; pipeline stalls when ex_valid=1 and ex_ready=0.
REQ-009 SHALL have port ld_valid  input  1  data-memory load response valid.
REQ-010 SHALL have port ld_rd  input  5  load destination register.
REQ-011 SHALL have port ld_data  input  DATA_W  load data (already sign/zero extended).
REQ-012 SHALL have port ld_ready  output  1  queue can accept a load response (= not full).
REQ-013 SHALL have port rf_we  output  1  register-file write enable, registered.
REQ-014 SHALL have port rf_waddr  output  5  register-file write address, registered.
REQ-015 SHALL have port rf_wdata  output  DATA_W  register-file write data, registered.
REQ-016 SHALL have port ld_pending  output  1  queue non-empty.

Function
REQ-017 SHALL push a load into the FIFO queue when ld_valid=1 and ld_ready=1; ld_ready SHALL depend on registered occupancy only.
REQ-018 SHALL drop, without queuing or granting the write port, any request whose rd is x0; such an ex request SHALL see ex_ready=1.
REQ-019 SHALL grant at most one requester per cycle; the winner is written on rf_* at the next rising edge (1-cycle latency); no grant gives rf_we=0.
REQ-020 SHALL, by default (fixed priority), grant the queue head when the queue is full, else grant ex when ex_valid=1, else grant the queue head when non-empty.
REQ-021 SHALL hold ex_ready=0 whenever ex_rd (non-zero) equals the rd of any queued entry (WAW ordering), forcing the queue head to be granted that cycle.
REQ-022 SHALL support push and pop in the same cycle, occupancy unchanged; a push into a full queue SHALL not occur (ld_ready=0).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width $clog2(DEPTH)+1.
REQ-024 SHALL assert ex_ready combinationally from current inputs and registered state; ex_ready=1 whenever ex_valid=0.
REQ-025 SHALL drive ld_pending=1 exactly when occupancy>0.

Reset
REQ-026 SHALL, on rst=1, clear immediately: rf_we=0, rf_waddr=0, rf_wdata=0, occupancy=0, pointers=0, round-robin pointer=ex.
REQ-027 SHALL discard queued loads and any in-flight grant on reset mid-operation; ld_ready=1 and ld_pending=0 while rst=1.

Configuration
REQ-028 SHALL, when macro WB_ARB_RR_EN is defined, replace REQ-020 with round-robin: when both ex and a non-full queue request, grant the one not granted last contended cycle; a full queue still wins.
REQ-029 SHALL, without WB_ARB_RR_EN, implement fixed priority per REQ-020 with no round-robin state.
REQ-030 SHALL keep REQ-021 ordering in both configurations.

Verification
REQ-031 SHALL cover: ex_valid=1, ex_rd=5, ex_data=0xDEAD_BEEF, queue empty -> ex_ready=1; next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEAD_BEEF.
REQ-032 SHALL cover: ld_valid=1 for two cycles (rd=3,4) with ex_valid=1 (rd=7) held -> queue full, ld_ready=0; then queue head rd=3 written, then fixed priority grants ex rd=7, then rd=4.
REQ-033 SHALL cover: queued load rd=9, ex_valid=1 ex_rd=9 -> ex_ready=0 until the rd=9 load writes; ex rd=9 written on the following edge.
REQ-034 SHALL cover: ex_rd=0 and ld_rd=0 requests -> rf_we stays 0, ex_ready=1, occupancy unchanged.
REQ-035 SHALL cover: rst pulsed asynchronously mid-cycle with 2 queued loads -> rf_we=0, ld_pending=0 immediately; no queued load written afterward.
REQ-036 SHALL cover, with WB_ARB_RR_EN: one queued load plus ex_valid continuously -> grants alternate ex, load, ex, ...

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file writeback arbiter. Merges the execute-path result
//            stream with data-memory load responses onto one register-file
//            write port. Load responses are buffered in a small FIFO. A
//            full FIFO always wins the port. A pending write to the same rd
//            in the FIFO blocks the execute path so that writes to one rd
//            land in program order. Writes to x0 are dropped.
// Config   : WB_ARB_RR_EN - when defined, an execute request that competes
//            with a non-full, non-empty FIFO is resolved round-robin.
//            Undefined (default): fixed priority, execute before queued
//            loads, with no round-robin state.
// Ports    : clk, rst           - clock (rising edge), async active-high reset
//            ex_valid/rd/data   - execute-path writeback request
//            ex_ready           - execute request granted (or dropped) now
//            ld_valid/rd/data   - load response into the FIFO
//            ld_ready           - FIFO not full (registered occupancy only)
//            rf_we/waddr/wdata  - registered register-file write port
//            ld_pending         - FIFO holds at least one load
// Revision : 1.0 - initial release
// ============================================================================

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module wb_arbiter #(
  parameter int DATA_W = `REG_WIDTH,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ld_pending
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Load FIFO state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [4:0]         rd_mem_q   [DEPTH];
  logic [c_PTR_W-1:0] wptr_q, wptr_d;
  logic [c_PTR_W-1:0] rptr_q, rptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;

  // Registered write port
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ex_req;
  logic w_waw;
  logic w_grant_ex;
  logic w_grant_q;

  logic [c_PTR_W-1:0] w_slot_off  [DEPTH];
  logic [DEPTH-1:0]   w_slot_live;
  logic [DEPTH-1:0]   w_slot_waw;

`ifdef WB_ARB_RR_EN
  // Which requester gets the next contended cycle.
  typedef enum logic {
    RR_EX = 1'b0,
    RR_LD = 1'b1
  } rr_e;

  rr_e rr_q, rr_d;
`endif

  assign w_full   = (count_q == c_FULL);
  assign w_empty  = (count_q == '0);
  assign w_ex_req = ex_valid && (ex_rd != 5'd0);

  // Loads to x0 are acknowledged but never stored.
  assign w_push   = ld_valid && !w_full && (ld_rd != 5'd0);

  // --------------------------------------------------------------------------
  // WAW detection: a slot is live when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy. Any live slot holding ex_rd blocks
  // the execute path.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_slot_off[g]  = c_PTR_W'(g) - rptr_q;
    assign w_slot_live[g] = ({1'b0, w_slot_off[g]} < count_q);
    assign w_slot_waw[g]  = w_slot_live[g] && (rd_mem_q[g] == ex_rd);
  end

  assign w_waw = w_ex_req && (|w_slot_waw);

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_ex = 1'b0;
    w_grant_q  = 1'b0;
`ifdef WB_ARB_RR_EN
    rr_d       = rr_q;
`endif
    if (w_full) begin
      // A full FIFO must drain or load responses would back up.
      w_grant_q = 1'b1;
    end else if (w_waw) begin
      // Older queued write to the same rd must land first; the FIFO is
      // necessarily non-empty here.
      w_grant_q = 1'b1;
    end else if (w_ex_req && !w_empty) begin
`ifdef WB_ARB_RR_EN
      if (rr_q == RR_LD) begin
        w_grant_q = 1'b1;
        rr_d      = RR_EX;
      end else begin
        w_grant_ex = 1'b1;
        rr_d       = RR_LD;
      end
`else
      w_grant_ex = 1'b1;
`endif
    end else if (w_ex_req) begin
      w_grant_ex = 1'b1;
    end else if (!w_empty) begin
      w_grant_q = 1'b1;
    end
  end

  assign w_pop = w_grant_q;

  // --------------------------------------------------------------------------
  // FIFO next state (push and pop may coincide)
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_push) begin
      wptr_d = wptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rptr_d = rptr_q + c_PTR_W'(1);
    end
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write-port next state
  // --------------------------------------------------------------------------
  always_comb begin
    rf_we_d    = w_grant_ex || w_grant_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (w_grant_ex) begin
      rf_waddr_d = ex_rd;
      rf_wdata_d = ex_data;
    end else if (w_grant_q) begin
      rf_waddr_d = rd_mem_q[rptr_q];
      rf_wdata_d = data_mem_q[rptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= RR_EX;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      data_mem_q[wptr_q] <= ld_data;
      rd_mem_q[wptr_q]   <= ld_rd;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ex_ready   = !ex_valid || (ex_rd == 5'd0) || w_grant_ex;
  assign ld_ready   = !w_full;
  assign ld_pending = !w_empty;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. Each scenario pushes the
//            register-file writes it expects onto a scoreboard queue; a
//            monitor pops and compares on every rf_we. Scenario tasks also
//            check handshake outputs inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0;
  logic        ex_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_pending;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  wb_arbiter #(.DATA_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .ex_ready   (ex_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .ld_pending (ld_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                   rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
            n_bad++;
            $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                     rf_waddr, rf_wdata, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b required 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr: got %0d required 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h required 0", rf_wdata); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ld_ready: got %b required 1", ld_ready); end
    n_cmp++; if (ld_pending !== 1'b0) begin n_bad++; $display("FAIL reset_ld_pending: got %b required 0", ld_pending); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ex_ready: got %b required 1", ex_ready); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_ex_write();
    tick();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL ex_ready_empty: got %b required 1", ex_ready); end
    expect_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL ex_latency: got we=%b addr=%0d data=%h required we=1 addr=5 data=deadbeef",
                        rf_we, rf_waddr, rf_wdata);
    end
    tick(); tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL ex_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_x0_drop();
    tick();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h1234_5678;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h8765_4321;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ex_ready: got %b required 1", ex_ready); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ld_ready: got %b required 1", ld_ready); end
    tick();
    idle();
    n_cmp++; if (ld_pending !== 1'b0) begin n_bad++; $display("FAIL x0_pending: got %b required 0", ld_pending); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_we: got %b required 0", rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_we_late: got %b required 0", rf_we); end
  endtask

  // Continuous loads with ex idle: push and pop every cycle, pointers wrap.
  task automatic test_back_to_back();
    tick();
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_rd    = 5'(11 + i);
      ld_data  = 32'hB0B0_0000 | 32'(i);
      if (i > 0) expect_wr(5'(10 + i), 32'hB0B0_0000 | 32'(i - 1));
      #1;
      n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ld_ready: got %b required 1 at load %0d", ld_ready, i); end
      tick();
    end
    idle();
    expect_wr(5'd16, 32'hB0B0_0005);
    tick();
    n_cmp++; if (ld_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_pending: got %b required 0", ld_pending); end
    tick(); tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_waw();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999_0009;
    tick();
    ld_valid = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'hA9A9_0009;
    #1;
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL waw_block: got %b required 0", ex_ready); end
    expect_wr(5'd9, 32'h9999_0009);
    tick();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b required 1", ex_ready); end
    expect_wr(5'd9, 32'hA9A9_0009);
    tick();
    idle();
    tick(); tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL waw_drain: got %0d left required 0", exp_q.size()); end
  endtask

`ifndef WB_ARB_RR_EN
  task automatic test_fixed_priority();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333_0003;
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h7000_0001;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL fp_ex_ready1: got %b required 1", ex_ready); end
    expect_wr(5'd7, 32'h7000_0001);
    tick();
    ld_rd = 5'd4; ld_data = 32'h4444_0004; ex_data = 32'h7000_0002;
    #1;
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL fp_ld_ready2: got %b required 1", ld_ready); end
    expect_wr(5'd7, 32'h7000_0002);
    tick();
    ld_valid = 1'b0; ex_data = 32'h7000_0003;
    #1;
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL fp_full_ld_ready: got %b required 0", ld_ready); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL fp_full_ex_ready: got %b required 0", ex_ready); end
    expect_wr(5'd3, 32'h3333_0003);
    tick();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL fp_ex_after: got %b required 1", ex_ready); end
    expect_wr(5'd7, 32'h7000_0003);
    tick();
    idle();
    n_cmp++; if (ld_pending !== 1'b1) begin n_bad++; $display("FAIL fp_pending: got %b required 1", ld_pending); end
    expect_wr(5'd4, 32'h4444_0004);
    tick();
    tick(); tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL fp_drain: got %0d left required 0", exp_q.size()); end
  endtask
`else
  task automatic test_round_robin();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h1010_000A;
    tick();
    ld_valid = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd11; ex_data = 32'hE000_0001;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rr_first_ex: got %b required 1", ex_ready); end
    expect_wr(5'd11, 32'hE000_0001);
    tick();
    ex_data = 32'hE000_0002;
    #1;
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL rr_load_turn: got %b required 0", ex_ready); end
    expect_wr(5'd10, 32'h1010_000A);
    tick();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rr_ex_again: got %b required 1", ex_ready); end
    expect_wr(5'd11, 32'hE000_0002);
    tick();
    idle();
    tick(); tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL rr_drain: got %0d left required 0", exp_q.size()); end
  endtask
`endif

  task automatic test_reset_mid();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020_0014;
    ex_valid = 1'b1; ex_rd = 5'd22; ex_data = 32'hC000_0001;
    expect_wr(5'd22, 32'hC000_0001);
    tick();
    ld_rd = 5'd21; ld_data = 32'h2121_0015; ex_data = 32'hC000_0002;
    expect_wr(5'd22, 32'hC000_0002);
    tick();
    idle();
    n_cmp++; if (ld_pending !== 1'b1) begin n_bad++; $display("FAIL rm_pending_before: got %b required 1", ld_pending); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rm_we: got %b required 0", rf_we); end
    n_cmp++; if (ld_pending !== 1'b0) begin n_bad++; $display("FAIL rm_pending: got %b required 0", ld_pending); end
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ld_ready: got %b required 1", ld_ready); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rm_we_held: got %b required 0", rf_we); end
    rst = 1'b0;
    repeat (4) tick();
    n_cmp++; if (ld_pending !== 1'b0) begin n_bad++; $display("FAIL rm_pending_after: got %b required 0", ld_pending); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL rm_drain: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_ex_write();
    test_x0_drop();
    test_back_to_back();
    test_waw();
`ifndef WB_ARB_RR_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
